spi_host_ctrl: RTL and testbench
================================

Name: spi_host_ctrl

Overview:
- SPI master (mode 0, CPOL=0) that produces the sclk/mosi/cs/miso link to periph_dev from the system clock.
- Serialises one 32-bit command frame {8'h00, addr[7:0], data[15:0]}, MSB first, on a single start pulse.
- Captures the 32 bits returned on MISO and reports completion with a one-cycle done pulse.
- Sits between the system-side controller (FSM or CPU bridge) and the SPI peripheral.

Parameters:
- CLK_DIV, 4, SCLK half-period in clk_i cycles (>=1); SCLK period is 2*CLK_DIV cycles.
- GAP_CYC, 2, clk_i cycles with cs_o high after a frame before busy_o falls (>=1).

Ports:
- clk_i  in  1  system clock; all logic on posedge.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  frame request; accepted only in a cycle where busy_o=0.
- addr_bi  in  8  frame address; sampled on accept.
- data_bi  in  16  frame payload; sampled on accept.
- busy_o  out  1  high from the cycle after accept until GAP ends.
- done_o  out  1  one-cycle pulse; rx_data_bo is valid from this cycle on.
- rx_data_bo  out  32  received MISO word, MSB = first bit sampled; holds until the next done_o.
- sclk_o  out  1  SPI clock, idles low.
- mosi_o  out  1  SPI data out.
- miso_i  in  1  SPI data in.
- cs_o  out  1  chip select, active-low.

Behaviour:
- Reset state (next posedge with rst_i=1, any state): cs_o=1, sclk_o=0, mosi_o=0, busy_o=0, done_o=0, rx_data_bo=0, FSM=IDLE.
- A reset mid-frame aborts immediately and emits no done_o. The system must then issue a peripheral reset frame, because periph_dev does not resync on cs.
- The FSM has five states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE: start_i=1 at cycle 0 latches the frame word and moves to SETUP. start_i is ignored in every other state; there is no queueing.
- SETUP (cycles 1..CLK_DIV): cs_o=0, busy_o=1, mosi_o=frame[31], sclk_o=0.
- SHIFT: sclk_o toggles every CLK_DIV cycles, giving exactly 32 rising and 32 falling edges.
  - The first rise is at cycle CLK_DIV+1.
  - The last fall is at cycle 64*CLK_DIV+1.
- MOSI timing: mosi_o changes only in the cycle sclk_o goes 1->0, advancing to the next lower bit. It is therefore stable across each high phase and the peripheral's sampling fall. After the 32nd fall it drives 0.
- MISO timing: miso_i is sampled in the cycle sclk_o goes 1->0 and shifted into the rx register LSB-first, so the first sample ends at bit 31.
- HOLD: sclk_o=0, cs_o=0 for CLK_DIV cycles.
- End of HOLD, at cycle 65*CLK_DIV+1:
  - cs_o goes to 1.
  - rx_data_bo is updated.
  - done_o pulses in that cycle.
- GAP: GAP_CYC cycles with cs_o=1, then busy_o=0 and the FSM is in IDLE.
  - With defaults, done_o is at cycle 261 and busy_o falls at cycle 263.
- Back-to-back operation: start_i held high starts the next frame in the first cycle with busy_o=0. The minimum cs_o high time is GAP_CYC+1 cycles.
- Readback mapping with periph_dev: rx_data_bo[16] = busy flag and rx_data_bo[15:0] = product y. Both are snapshotted at the frame's first SCLK rise.
- Counters:
  - Half-period counter is $clog2(CLK_DIV)+1 bits and wraps to 0 on each toggle.
  - Edge counter is 7 bits, counting 0..63.
  - No arithmetic overflow is possible.

Decomposition:
- spi_pkg holds:
  - FRAME_BITS=32.
  - Peripheral address constants SPI_ADDR_RESET=8'h00 and SPI_ADDR_OP=8'h01.
  - Frame field positions: addr [23:16], data [15:0], readback busy bit 16, y [15:0].
  - FSM state typedef {IDLE, SETUP, SHIFT, HOLD, GAP}.
- One sub-module, spi_clk_gen: the half-period counter. It emits a one-cycle rise_p/fall_p strobe and the sclk level when enabled, and is cleared by rst_i or disable.
- Shift registers and the FSM stay in spi_host_ctrl.

Test Plan:
- Reset: assert rst_i for 3 cycles -> cs_o=1, sclk_o=0, mosi_o=0, busy_o=0, done_o=0, rx_data_bo=32'h0.
- Single frame, CLK_DIV=4, addr=8'h01, data=16'h0A0B:
  - A monitor sampling mosi on sclk falls decodes 32'h00010A0B.
  - Exactly 32 rises and 32 falls occur.
  - done_o is at cycle 261 and busy_o falls at cycle 263.
- MISO capture: a slave model drives the next bit of 32'hDEADBEEF on each sclk rise, starting with bit 31 -> rx_data_bo=32'hDEADBEEF at done_o.
- start_i pulsed at cycles 5 and 100 during a frame -> both ignored, one done_o. start_i held high -> the second frame's cs_o falls 3 cycles after the first rises (GAP_CYC=2).
- rst_i asserted one cycle at the 20th sclk edge -> next cycle cs_o=1, sclk_o=0, busy_o=0; no done_o; rx_data_bo=0.
- Integration with periph_dev, multiplying 12 by 13:
  - Send frames (addr 8'h00, data 16'h0001), (8'h00, 16'h0000), then (8'h01, 16'h0C0D).
  - Poll with (8'h02, 16'h0000) until rx_data_bo[16]=0 -> rx_data_bo[15:0]=16'h009C.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI host definitions: frame layout, peripheral addresses and FSM state encoding.
// Declarations only; adds no latency.
// No flow control of its own; users decide how these fields are driven.
package spi_pkg;

   localparam int FRAME_BITS = 32;

   // Register addresses understood by the attached peripheral
   localparam logic [7:0] SPI_ADDR_RESET = 8'h00;
   localparam logic [7:0] SPI_ADDR_OP    = 8'h01;

   // Outgoing frame layout: {8'h00, addr, data}
   localparam int FRM_ADDR_MSB = 23;
   localparam int FRM_ADDR_LSB = 16;
   localparam int FRM_DATA_MSB = 15;
   localparam int FRM_DATA_LSB = 0;

   // Readback layout returned by the peripheral
   localparam int RB_BUSY_BIT = 16;
   localparam int RB_Y_MSB    = 15;
   localparam int RB_Y_LSB    = 0;

   // Host FSM encoding, kept as plain constants so older tools can match on them
   typedef logic [2:0] spi_state_t;
   localparam spi_state_t IDLE  = 3'd0;
   localparam spi_state_t SETUP = 3'd1;
   localparam spi_state_t SHIFT = 3'd2;
   localparam spi_state_t HOLD  = 3'd3;
   localparam spi_state_t GAP   = 3'd4;

   // Build the outgoing command word; the top byte is always zero
   function automatic logic [FRAME_BITS-1:0] spi_frame(input logic [7:0]  addr,
                                                       input logic [15:0] data);
      logic [FRAME_BITS-1:0] f;
      f = '0;
      f[FRM_ADDR_MSB:FRM_ADDR_LSB] = addr;
      f[FRM_DATA_MSB:FRM_DATA_LSB] = data;
      return f;
   endfunction

endpackage

// File: rtl/spi_host_ctrl_if.sv
// System-side command/response bundle of the SPI host: start request, frame fields, status and readback.
// Pure wiring, zero latency.
// The requester must hold off start_i while busy_o is high; a start during busy is dropped, never queued.
interface spi_host_ctrl_if;
   import spi_pkg::*;

   logic                  start_i;
   logic [7:0]            addr_bi;
   logic [15:0]           data_bi;
   logic                  busy_o;
   logic                  done_o;
   logic [FRAME_BITS-1:0] rx_data_bo;

   // Requester side (system FSM or CPU bridge)
   modport master (
      output start_i, addr_bi, data_bi,
      input  busy_o, done_o, rx_data_bo
   );

   // SPI host side
   modport slave (
      input  start_i, addr_bi, data_bi,
      output busy_o, done_o, rx_data_bo
   );

endinterface

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period counter producing the SCLK level plus edge strobes.
// Strobes are combinational and mark the cycle whose closing clock edge toggles SCLK.
// No backpressure; enable low (or reset) clears the counter and parks SCLK low.
module spi_clk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en,
   output logic sclk,
   output logic rise_p,
   output logic fall_p
);

   localparam int               CNT_W    = $clog2(CLK_DIV) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic             tick;

   // The edge that closes a tick cycle flips SCLK, so the owner can move data on that same edge
   assign tick   = en && (cnt == CNT_LAST);
   assign rise_p = tick && !sclk;
   assign fall_p = tick &&  sclk;

   // Count clk_i cycles within each half-period and wrap to 0 on every toggle
   always_ff @(posedge clk_i) begin
      if (rst_i || !en) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else if (tick) begin
         cnt  <= '0;
         sclk <= ~sclk;
      end else begin
         cnt  <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/spi_host_ctrl.sv
// SPI mode-0 host: sends one 32-bit {8'h00, addr, data} frame MSB first and captures 32 MISO bits.
// done_o lands 65*CLK_DIV+1 cycles after accept; busy_o drops GAP_CYC cycles later.
// start_i is only taken while busy_o is low; requests during a frame are dropped, not queued.
module spi_host_ctrl
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int GAP_CYC = 2
) (
   input  logic           clk_i,
   input  logic           rst_i,
   spi_host_ctrl_if.slave host,
   output logic           sclk_o,
   output logic           mosi_o,
   input  logic           miso_i,
   output logic           cs_o
);

   // One timer serves both the HOLD and GAP phases, so size it for the longer one
   localparam int               TMR_MAX   = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
   localparam int               TMR_W     = $clog2(TMR_MAX) + 1;
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYC - 1);
   localparam logic [6:0]       EDGE_LAST = 7'd63;

   spi_state_t            state;
   logic [FRAME_BITS-1:0] frame_in;
   logic [FRAME_BITS-1:0] tx_sh;
   logic [FRAME_BITS-1:0] rx_sh;
   logic [FRAME_BITS-1:0] rx_data;
   logic [6:0]            edge_cnt;
   logic [TMR_W-1:0]      tmr;
   logic                  cs;
   logic                  busy;
   logic                  done;
   logic                  clk_en;
   logic                  sclk;
   logic                  rise_p;
   logic                  fall_p;

   assign frame_in = spi_frame(host.addr_bi, host.data_bi);
   assign clk_en   = (state == SETUP) || (state == SHIFT);

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en     (clk_en),
      .sclk   (sclk),
      .rise_p (rise_p),
      .fall_p (fall_p)
   );

   // MOSI is the top of the shifter; after 32 left shifts it is all zeros, so the line idles at 0
   assign mosi_o          = tx_sh[FRAME_BITS-1];
   assign sclk_o          = sclk;
   assign cs_o            = cs;
   assign host.busy_o     = busy;
   assign host.done_o     = done;
   assign host.rx_data_bo = rx_data;

   // Frame sequencer: accept, shift 32 bits on SCLK falls, hold CS low, then enforce the CS-high gap
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         tx_sh    <= '0;
         rx_sh    <= '0;
         rx_data  <= '0;
         edge_cnt <= '0;
         tmr      <= '0;
         cs       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (host.start_i) begin
                  tx_sh    <= frame_in;
                  rx_sh    <= '0;
                  edge_cnt <= '0;
                  cs       <= 1'b0;
                  busy     <= 1'b1;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               // MSB already sits on MOSI; wait out one half-period before the first rise
               if (rise_p) begin
                  edge_cnt <= edge_cnt + 7'd1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (rise_p) begin
                  edge_cnt <= edge_cnt + 7'd1;
               end else if (fall_p) begin
                  // Peripheral drives MISO on the rise, so it is settled by the fall
                  rx_sh <= {rx_sh[FRAME_BITS-2:0], miso_i};
                  tx_sh <= {tx_sh[FRAME_BITS-2:0], 1'b0};
                  if (edge_cnt == EDGE_LAST) begin
                     tmr   <= '0;
                     state <= HOLD;
                  end else begin
                     edge_cnt <= edge_cnt + 7'd1;
                  end
               end
            end
            HOLD: begin
               if (tmr == HOLD_LAST) begin
                  cs      <= 1'b1;
                  done    <= 1'b1;
                  rx_data <= rx_sh;
                  tmr     <= '0;
                  state   <= GAP;
               end else begin
                  tmr <= tmr + TMR_W'(1);
               end
            end
            GAP: begin
               if (tmr == GAP_LAST) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  tmr <= tmr + TMR_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_host_ctrl.sv
// Directed bench for spi_host_ctrl: frame timing, MOSI/MISO data, start filtering, abort and a peripheral model.
// Inputs change #1 after the falling clock edge; outputs are read there too.
// The peripheral model answers on SCLK rises and decodes commands when CS rises after a full frame.
module tb_spi_host_ctrl;
   import spi_pkg::*;

   logic clk_i  = 1'b0;
   logic rst_i  = 1'b1;
   logic sclk_o;
   logic mosi_o;
   logic cs_o;
   logic miso_i = 1'b0;

   spi_host_ctrl_if host_if ();

   spi_host_ctrl #(
      .CLK_DIV (4),
      .GAP_CYC (2)
   ) dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .host   (host_if),
      .sclk_o (sclk_o),
      .mosi_o (mosi_o),
      .miso_i (miso_i),
      .cs_o   (cs_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- cycle counter and link monitor ----------------
   int          cyc = 0;
   int          t0 = 0;
   int          n_rise = 0, n_fall = 0, n_done = 0, n_cs_fall = 0;
   int          done_at = 0, busy_fall_at = 0, cs_rise_abs = 0, cs_fall_abs = 0;
   logic [31:0] mosi_word = 32'h0;
   logic [31:0] rx_at_done = 32'h0;
   logic        prv_sclk = 1'b0, prv_mosi = 1'b0, prv_busy = 1'b0, prv_cs = 1'b1;

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(negedge clk_i) begin
      if (sclk_o === 1'b1 && prv_sclk === 1'b0) n_rise++;
      if (sclk_o === 1'b0 && prv_sclk === 1'b1) begin
         n_fall++;
         mosi_word = {mosi_word[30:0], prv_mosi};
      end
      if (host_if.done_o === 1'b1) begin
         n_done++;
         done_at    = cyc - t0;
         rx_at_done = host_if.rx_data_bo;
      end
      if (host_if.busy_o === 1'b0 && prv_busy === 1'b1) busy_fall_at = cyc - t0;
      if (cs_o === 1'b1 && prv_cs === 1'b0) cs_rise_abs = cyc;
      if (cs_o === 1'b0 && prv_cs === 1'b1) begin
         cs_fall_abs = cyc;
         n_cs_fall++;
      end
      prv_sclk = sclk_o;
      prv_mosi = mosi_o;
      prv_busy = host_if.busy_o;
      prv_cs   = cs_o;
   end

   // ---------------- SPI slave: fixed pattern or peripheral model ----------------
   localparam logic [31:0] SLV_PAT = 32'hDEADBEEF;
   bit          pdev_mode = 1'b0;
   int          pd_rise = 0;
   logic [31:0] pd_tx = 32'h0;
   logic [31:0] pd_rx = 32'h0;
   logic        pd_rst = 1'b1;
   int          pd_cd = 0;
   logic [15:0] pd_y = 16'h0;

   always @(posedge sclk_o or posedge cs_o) begin
      if (cs_o === 1'b1) begin
         if (pdev_mode && pd_rise == 32) begin
            case (pd_rx[23:16])
               SPI_ADDR_RESET: begin
                  pd_rst = pd_rx[0];
                  if (pd_rx[0]) begin
                     pd_y  = 16'h0;
                     pd_cd = 0;
                  end
               end
               SPI_ADDR_OP: begin
                  if (!pd_rst) begin
                     pd_y  = 16'(pd_rx[15:8]) * 16'(pd_rx[7:0]);
                     pd_cd = 2;
                  end
               end
               default: begin
                  if (pd_cd > 0) pd_cd--;
               end
            endcase
         end
         pd_rise = 0;
      end else begin
         if (pd_rise == 0)
            pd_tx = pdev_mode ? {15'h0, (pd_cd != 0), pd_y} : SLV_PAT;
         miso_i <= pd_tx[31];
         pd_tx   = {pd_tx[30:0], 1'b0};
         pd_rx   = {pd_rx[30:0], mosi_o};
         pd_rise++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk_i);
      #1;
   endtask

   // Wait for an idle host, then present a one-cycle start; t0 marks the accept cycle
   task automatic send_start(input logic [7:0] a, input logic [15:0] d);
      for (int k = 0; k < 1000 && host_if.busy_o !== 1'b0; k++) tick();
      host_if.addr_bi = a;
      host_if.data_bi = d;
      host_if.start_i = 1'b1;
      t0 = cyc;
      tick();
      host_if.start_i = 1'b0;
   endtask

   task automatic xfer(input string tag, input logic [7:0] a, input logic [15:0] d);
      int d0;
      d0 = n_done;
      send_start(a, d);
      for (int k = 0; k < 600 && !(n_done > d0 && host_if.busy_o === 1'b0); k++) tick();
      if (!(n_done > d0 && host_if.busy_o === 1'b0)) chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int r0, f0, d0, c0, e0, polls;
      logic [31:0] rb;
      host_if.start_i = 1'b0;
      host_if.addr_bi = 8'h00;
      host_if.data_bi = 16'h0000;

      // ---- reset state ----
      rst_i = 1'b1;
      repeat (3) tick();
      chk("rst_cs",   {31'h0, cs_o}, 32'd1);
      chk("rst_sclk", {31'h0, sclk_o}, 32'd0);
      chk("rst_mosi", {31'h0, mosi_o}, 32'd0);
      chk("rst_busy", {31'h0, host_if.busy_o}, 32'd0);
      chk("rst_done", {31'h0, host_if.done_o}, 32'd0);
      chk("rst_rx",   host_if.rx_data_bo, 32'h0);
      rst_i = 1'b0;
      repeat (2) tick();

      // ---- single frame with stray starts at cycles 5 and 100 ----
      r0 = n_rise; f0 = n_fall; d0 = n_done;
      send_start(8'h01, 16'h0A0B);
      for (int k = 0; k < 600 && !(n_done > d0 && host_if.busy_o === 1'b0); k++) begin
         tick();
         host_if.start_i = ((cyc - t0) == 5) || ((cyc - t0) == 100);
      end
      host_if.start_i = 1'b0;
      chk("a_done_cnt",  n_done - d0, 32'd1);
      chk("a_mosi",      mosi_word, 32'h00010A0B);
      chk("a_rises",     n_rise - r0, 32'd32);
      chk("a_falls",     n_fall - f0, 32'd32);
      chk("a_done_at",   done_at, 32'd261);
      chk("a_busy_fall", busy_fall_at, 32'd263);
      chk("a_rx",        rx_at_done, 32'hDEADBEEF);
      repeat (10) tick();
      chk("a_no_extra",  n_done - d0, 32'd1);
      chk("a_idle_busy", {31'h0, host_if.busy_o}, 32'd0);
      chk("a_rx_hold",   host_if.rx_data_bo, 32'hDEADBEEF);

      // ---- back-to-back with start held high ----
      d0 = n_done; c0 = n_cs_fall;
      host_if.addr_bi = 8'h12;
      host_if.data_bi = 16'h3456;
      host_if.start_i = 1'b1;
      for (int k = 0; k < 600 && n_done <= d0; k++) tick();
      for (int k = 0; k < 50 && n_cs_fall < c0 + 2; k++) tick();
      host_if.start_i = 1'b0;
      chk("b2b_cs_high", cs_fall_abs - cs_rise_abs, 32'd3);
      for (int k = 0; k < 600 && !(n_done > d0 + 1 && host_if.busy_o === 1'b0); k++) tick();
      chk("b2b_done_cnt", n_done - d0, 32'd2);
      chk("b2b_mosi",     mosi_word, 32'h00123456);

      // ---- reset at the 20th SCLK edge ----
      e0 = n_rise + n_fall; d0 = n_done;
      send_start(8'h55, 16'hAAAA);
      for (int k = 0; k < 200 && (n_rise + n_fall - e0) < 20; k++) tick();
      chk("ab_edges", n_rise + n_fall - e0, 32'd20);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("ab_cs",   {31'h0, cs_o}, 32'd1);
      chk("ab_sclk", {31'h0, sclk_o}, 32'd0);
      chk("ab_busy", {31'h0, host_if.busy_o}, 32'd0);
      chk("ab_mosi", {31'h0, mosi_o}, 32'd0);
      chk("ab_rx",   host_if.rx_data_bo, 32'h0);
      repeat (300) tick();
      chk("ab_no_done", n_done - d0, 32'd0);

      // ---- peripheral integration: 12 * 13 ----
      pdev_mode = 1'b1;
      xfer("pd_rst1", SPI_ADDR_RESET, 16'h0001);
      xfer("pd_rst0", SPI_ADDR_RESET, 16'h0000);
      xfer("pd_op",   SPI_ADDR_OP,    16'h0C0D);
      polls = 0;
      rb = 32'h0001_0000;
      while (rb[RB_BUSY_BIT] !== 1'b0 && polls < 8) begin
         xfer("pd_poll", 8'h02, 16'h0000);
         rb = host_if.rx_data_bo;
         polls++;
         if (polls == 1) chk("pd_poll1_busy", {31'h0, rb[RB_BUSY_BIT]}, 32'd1);
      end
      chk("pd_y",     {16'h0, rb[RB_Y_MSB:RB_Y_LSB]}, 32'h0000009C);
      chk("pd_polls", polls, 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
